// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default width
// and the HI/LO destination select used by both the divide and multiply units.
package div_pkg;

  localparam int DIV_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  typedef enum logic {
    SEL_LO = 1'b0,
    SEL_HI = 1'b1
  } hilo_sel_e;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: used for operand magnitudes and for
// restoring the sign of the quotient and remainder.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             i_neg,
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + 1'b1) : i_val;

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider, one quotient bit per clock. Works on operand
// magnitudes and restores signs in a final fix-up cycle; remainder -> hi, quotient -> lo.
module div_seq import div_pkg::*; #(
  parameter int WIDTH = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signedMode,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_num, r_den, r_rem, r_quo, r_hi, r_lo;
  logic             r_q_neg, r_r_neg, r_done, r_div_zero;

  logic             w_a_neg, w_b_neg, w_b_zero, w_ge;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_quo_fix, w_rem_fix;
  logic [WIDTH:0]   w_rem_sh, w_diff;

  assign w_a_neg  = signedMode & srcA[WIDTH-1];
  assign w_b_neg  = signedMode & srcB[WIDTH-1];
  assign w_b_zero = (srcB == '0);

  div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (.i_neg(w_a_neg), .i_val(srcA), .o_val(w_abs_a));
  div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (.i_neg(w_b_neg), .i_val(srcB), .o_val(w_abs_b));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.i_neg(r_q_neg), .i_val(r_quo), .o_val(w_quo_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.i_neg(r_r_neg), .i_val(r_rem), .o_val(w_rem_fix));

  // Shifted partial remainder keeps its top bit, so the trial subtract needs WIDTH+1 bits;
  // the borrow out of the subtract is the restoring decision.
  assign w_rem_sh = {r_rem, r_num[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_den};
  assign w_ge     = ~w_diff[WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default before the case, otherwise an
  // unassigned path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start && !w_b_zero) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_cnt == LAST_CNT)  w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_num      <= '0;
      r_den      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && w_b_zero) begin
            r_div_zero <= 1'b1;
            r_done     <= 1'b1;
          end else if (start) begin
            r_num      <= w_abs_a;
            r_den      <= w_abs_b;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_q_neg    <= w_a_neg ^ w_b_neg;
            r_r_neg    <= w_a_neg;
            r_div_zero <= 1'b0;
          end
        end
        ST_RUN: begin
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
          r_num <= r_num << 1;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
        end
        ST_FIX: begin
          r_lo   <= w_quo_fix;
          r_hi   <= w_rem_fix;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy    = (r_state == ST_RUN) || (r_state == ST_FIX);
    done    = r_done;
    divZero = r_div_zero;
    hi      = r_hi;
    lo      = r_lo;
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: 32-bit and 8-bit instances, table vectors,
// handshake/reset corner sequences and random operands against an arithmetic model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start32, sm32, busy32, done32, dz32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        start8, sm8, busy8, done8, dz8;
  logic [7:0]  a8, b8, hi8, lo8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst_n), .start(start32), .signedMode(sm32), .srcA(a32), .srcB(b32),
    .busy(busy32), .done(done32), .divZero(dz32), .hi(hi32), .lo(lo32)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .signedMode(sm8), .srcA(a8), .srcB(b8),
    .busy(busy8), .done(done8), .divZero(dz8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    int          w;
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division on sign-extended values, truncated to w bits.
  function automatic void ref_div(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sm, output logic [31:0] hi, output logic [31:0] lo);
    longint mask = (longint'(1) << w) - 1;
    longint va   = longint'(a) & mask;
    longint vb   = longint'(b) & mask;
    longint q, r;
    if (sm && va[w-1]) va = va - (longint'(1) << w);
    if (sm && vb[w-1]) vb = vb - (longint'(1) << w);
    q  = va / vb;
    r  = va % vb;
    lo = 32'(q & mask);
    hi = 32'(r & mask);
  endfunction

  function automatic logic busy_of(input int w); return (w == 8) ? busy8 : busy32; endfunction
  function automatic logic done_of(input int w); return (w == 8) ? done8 : done32; endfunction
  function automatic logic dz_of(input int w);   return (w == 8) ? dz8   : dz32;   endfunction
  function automatic logic [31:0] hi_of(input int w); return (w == 8) ? {24'd0, hi8} : hi32; endfunction
  function automatic logic [31:0] lo_of(input int w); return (w == 8) ? {24'd0, lo8} : lo32; endfunction

  task automatic drive(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic sm);
    if (w == 8) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; sm8 = sm;
    end else begin
      start32 = st; a32 = a; b32 = b; sm32 = sm;
    end
  endtask

  // Pulses start, then samples 1 time unit after each edge until done. lat counts edges
  // after the accepting edge; bcnt counts samples with busy high. rp_at >= 0 re-pulses
  // start with different operands at that sample.
  task automatic run_div(input int w, input logic [31:0] a, input logic [31:0] b, input logic sm,
                         input int rp_at, output logic [31:0] hi, output logic [31:0] lo,
                         output logic dz, output int lat, output int bcnt);
    logic got = 1'b0;
    lat = -1; bcnt = 0; hi = '0; lo = '0; dz = 1'b0;
    drive(w, 1'b1, a, b, sm);
    @(posedge clk); #1;
    for (int k = 0; k <= 80; k++) begin
      if (busy_of(w)) bcnt++;
      if (done_of(w)) begin
        got = 1'b1; lat = k; hi = hi_of(w); lo = lo_of(w); dz = dz_of(w);
        break;
      end
      drive(w, k == rp_at, (k == rp_at) ? 32'd50 : a, (k == rp_at) ? 32'd5 : b, sm);
      @(posedge clk); #1;
    end
    drive(w, 1'b0, a, b, sm);
    check("done_seen", {63'd0, got}, 64'd1);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] ones = (w == 8) ? 32'hFF : 32'hFFFF_FFFF;
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1 << (w - 1);
      2:       return ones;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom & ones;
    endcase
  endfunction

  vec_t        vecs[14];
  logic [31:0] g_hi, g_lo, e_hi, e_lo;
  logic        g_dz;
  int          g_lat, g_bcnt;
  logic [31:0] prev_hi[2], prev_lo[2];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(32, 1'b0, 0, 0, 0);
    drive(8, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy32", {63'd0, busy32}, 0);
    check("rst_done32", {63'd0, done32}, 0);
    check("rst_dz32",   {63'd0, dz32}, 0);
    check("rst_hi32",   {32'd0, hi32}, 0);
    check("rst_lo32",   {32'd0, lo32}, 0);
    check("rst_busy8",  {63'd0, busy8}, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = '{32, 32'd100,        32'd7,          1'b0, 32'd2,          32'd14};
    vecs[1]  = '{32, 32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFD};
    vecs[2]  = '{32, 32'd7,          32'hFFFF_FFFE,  1'b1, 32'd1,          32'hFFFF_FFFD};
    vecs[3]  = '{32, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000};
    vecs[4]  = '{32, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0};
    vecs[5]  = '{8,  32'd200,        32'd3,          1'b0, 32'd2,          32'd66};
    vecs[6]  = '{8,  32'h80,         32'hFF,         1'b1, 32'd0,          32'h80};
    vecs[7]  = '{32, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          32'hFFFF_FFFF};
    vecs[8]  = '{32, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'd1};
    vecs[9]  = '{32, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFF,  32'd3};
    vecs[10] = '{8,  32'h81,         32'd2,          1'b1, 32'hFF,         32'hC1};
    vecs[11] = '{32, 32'd5,          32'd10,         1'b0, 32'd5,          32'd0};
    vecs[12] = '{32, 32'hFFFF_FFFE,  32'h8000_0000,  1'b0, 32'h7FFF_FFFE,  32'd1};
    vecs[13] = '{8,  32'hFF,         32'h80,         1'b0, 32'h7F,         32'd1};

    for (int i = 0; i < 14; i++) begin
      run_div(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].sm, -1, g_hi, g_lo, g_dz, g_lat, g_bcnt);
      check($sformatf("vec%0d_lo", i),   {32'd0, g_lo}, {32'd0, vecs[i].lo});
      check($sformatf("vec%0d_hi", i),   {32'd0, g_hi}, {32'd0, vecs[i].hi});
      check($sformatf("vec%0d_dz", i),   {63'd0, g_dz}, 0);
      check($sformatf("vec%0d_lat", i),  64'(g_lat),    64'(vecs[i].w + 1));
      check($sformatf("vec%0d_busy", i), 64'(g_bcnt),   64'(vecs[i].w + 1));
    end

    // 100/7, then done must drop after one cycle and results must hold.
    run_div(32, 32'd100, 32'd7, 1'b0, -1, g_hi, g_lo, g_dz, g_lat, g_bcnt);
    @(posedge clk); #1;
    check("pulse_done_low", {63'd0, done32}, 0);
    check("hold_lo", {32'd0, lo32}, 64'd14);
    check("hold_hi", {32'd0, hi32}, 64'd2);

    // Divide by zero: immediate done, flag set, hi/lo untouched, busy never high.
    run_div(32, 32'd5, 32'd0, 1'b1, -1, g_hi, g_lo, g_dz, g_lat, g_bcnt);
    check("dz_flag", {63'd0, g_dz}, 1);
    check("dz_lat",  64'(g_lat), 0);
    check("dz_busy", 64'(g_bcnt), 0);
    check("dz_hi",   {32'd0, g_hi}, 64'd2);
    check("dz_lo",   {32'd0, g_lo}, 64'd14);
    // Start issued in the done cycle is accepted and clears the flag.
    run_div(32, 32'd9, 32'd3, 1'b0, -1, g_hi, g_lo, g_dz, g_lat, g_bcnt);
    check("b2b_lo",  {32'd0, g_lo}, 64'd3);
    check("b2b_dz",  {63'd0, g_dz}, 0);
    check("b2b_lat", 64'(g_lat), 64'd33);
    // Back-to-back again, with start re-pulsed mid-operation (must be ignored).
    run_div(32, 32'd100, 32'd7, 1'b0, 5, g_hi, g_lo, g_dz, g_lat, g_bcnt);
    check("rp_lo",  {32'd0, g_lo}, 64'd14);
    check("rp_hi",  {32'd0, g_hi}, 64'd2);
    check("rp_lat", 64'(g_lat), 64'd33);

    // Asynchronous reset in the middle of RUN.
    drive(32, 1'b1, 32'd1000, 32'd7, 1'b0);
    @(posedge clk); #1;
    drive(32, 1'b0, 32'd1000, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy32}, 0);
    check("arst_done", {63'd0, done32}, 0);
    check("arst_hi",   {32'd0, hi32}, 0);
    check("arst_lo",   {32'd0, lo32}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_div(32, 32'd9, 32'd3, 1'b0, -1, g_hi, g_lo, g_dz, g_lat, g_bcnt);
    check("arst_re_lo", {32'd0, g_lo}, 64'd3);
    check("arst_re_hi", {32'd0, g_hi}, 64'd0);

    // Random operands against the arithmetic model, both widths.
    prev_hi[0] = '0; prev_lo[0] = '0;
    prev_hi[1] = 32'd0; prev_lo[1] = 32'd3;
    for (int i = 0; i < 300; i++) begin
      int          w   = ($urandom_range(0, 3) == 0) ? 8 : 32;
      int          idx = (w == 8) ? 0 : 1;
      logic        sm  = 1'($urandom_range(0, 1));
      logic [31:0] a   = pick(w);
      logic [31:0] b   = pick(w);
      run_div(w, a, b, sm, -1, g_hi, g_lo, g_dz, g_lat, g_bcnt);
      if (b == 32'd0) begin
        e_hi = prev_hi[idx];
        e_lo = prev_lo[idx];
      end else begin
        ref_div(w, a, b, sm, e_hi, e_lo);
      end
      check($sformatf("rnd%0d_w%0d_lo(%h/%h,s%0d)", i, w, a, b, sm), {32'd0, g_lo}, {32'd0, e_lo});
      check($sformatf("rnd%0d_w%0d_hi(%h/%h,s%0d)", i, w, a, b, sm), {32'd0, g_hi}, {32'd0, e_hi});
      check($sformatf("rnd%0d_dz", i),  {63'd0, g_dz}, {63'd0, (b == 32'd0)});
      check($sformatf("rnd%0d_lat", i), 64'(g_lat), (b == 32'd0) ? 64'd0 : 64'(w + 1));
      prev_hi[idx] = e_hi;
      prev_lo[idx] = e_lo;
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
